// File: rtl/irrigation_scheduler.sv
// Watering request scheduler: decides when and how long to water, hands the duration
// to the pump controller and follows its handshake through completion, cooldown and fault.
module irrigation_scheduler #(
    parameter int unsigned DRY_THRESH  = 100,
    parameter int unsigned DUR_BASE    = 10,
    parameter int unsigned DUR_SHIFT   = 2,
    parameter int unsigned DUR_MAX     = 32,
    parameter int unsigned ACK_TIMEOUT = 8,
    parameter int unsigned COOLDOWN    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] moisture,
    input  logic       moisture_valid,
    input  logic       manual_req,
    input  logic [7:0] manual_dur,
    input  logic       sensor_enable,
    input  logic       watering_in_progress,
    input  logic       clear_fault,
    output logic [7:0] irrigation_time,
    output logic       busy,
    output logic       fault,
    output logic [7:0] water_count,
    output logic [7:0] last_duration
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_DONE,
        S_COOLDOWN,
        S_FAULT
    } state_t;

    localparam int CNT_W = 16;
    localparam logic [7:0]       DRY_T  = 8'(DRY_THRESH);
    localparam logic [7:0]       DUR_B  = 8'(DUR_BASE);
    localparam logic [7:0]       DUR_M  = 8'(DUR_MAX);
    localparam logic [CNT_W-1:0] ACK_T  = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] COOL_T = CNT_W'(COOLDOWN);

    // Deficit-scaled duration, clamped to DUR_MAX and never zero (zero means "no request").
    function automatic logic [7:0] auto_duration(input logic [7:0] m);
        logic [7:0] deficit;
        logic [8:0] sum;
        logic [7:0] d;
        deficit = DRY_T - m;
        sum     = {1'b0, DUR_B} + {1'b0, deficit >> DUR_SHIFT};
        if (sum > {1'b0, DUR_M}) d = DUR_M;
        else                     d = sum[7:0];
        if (d == 8'd0) d = 8'd1;
        return d;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t           state, state_nxt;
    logic [7:0]       irr_q, irr_nxt;
    logic [7:0]       dur_q, dur_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt, cnt_inc;
    logic [7:0]       wc_q, wc_nxt;
    logic [7:0]       ld_q, ld_nxt;

    assign cnt_inc         = cnt_q + CNT_W'(1);
    assign irrigation_time = irr_q;
    assign busy            = (state != S_IDLE);
    assign fault           = (state == S_FAULT);
    assign water_count     = wc_q;
    assign last_duration   = ld_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            irr_q <= 8'd0;
            dur_q <= 8'd0;
            cnt_q <= '0;
            wc_q  <= 8'd0;
            ld_q  <= 8'd0;
        end else begin
            state <= state_nxt;
            irr_q <= irr_nxt;
            dur_q <= dur_nxt;
            cnt_q <= cnt_nxt;
            wc_q  <= wc_nxt;
            ld_q  <= ld_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        irr_nxt   = irr_q;
        dur_nxt   = dur_q;
        cnt_nxt   = cnt_q;
        wc_nxt    = wc_q;
        ld_nxt    = ld_q;
        case (state)
            S_IDLE: begin
                irr_nxt = 8'd0;
                cnt_nxt = '0;
                if (enable && sensor_enable) begin
                    // Manual request outranks an automatic dry reading.
                    if (manual_req && (manual_dur != 8'd0)) begin
                        dur_nxt   = manual_dur;
                        irr_nxt   = manual_dur;
                        state_nxt = S_REQ;
                    end else if (moisture_valid && (moisture < DRY_T)) begin
                        dur_nxt   = auto_duration(moisture);
                        irr_nxt   = auto_duration(moisture);
                        state_nxt = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // An ack arriving on the timeout cycle still counts.
                if (watering_in_progress) begin
                    irr_nxt   = 8'd0;
                    cnt_nxt   = '0;
                    state_nxt = S_WAIT_DONE;
                end else if (cnt_inc >= ACK_T) begin
                    irr_nxt   = 8'd0;
                    cnt_nxt   = '0;
                    state_nxt = S_FAULT;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            S_WAIT_DONE: begin
                irr_nxt = 8'd0;
                if (!watering_in_progress) begin
                    wc_nxt    = sat_inc(wc_q);
                    ld_nxt    = dur_q;
                    cnt_nxt   = '0;
                    state_nxt = S_COOLDOWN;
                end
            end
            S_COOLDOWN: begin
                irr_nxt = 8'd0;
                if (cnt_inc >= COOL_T) begin
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            S_FAULT: begin
                irr_nxt = 8'd0;
                cnt_nxt = '0;
                if (clear_fault) state_nxt = S_IDLE;
            end
            default: begin
                irr_nxt   = 8'd0;
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Bench for irrigation_scheduler: event-level reference model, simple pump-controller
// responder and directed scenarios with hand-computed expectations.
module tb_irrigation_scheduler;

    localparam int DRY_THRESH  = 100;
    localparam int DUR_BASE    = 10;
    localparam int DUR_SHIFT   = 2;
    localparam int DUR_MAX     = 32;
    localparam int ACK_TIMEOUT = 8;
    localparam int COOLDOWN    = 16;

    logic       clk = 1'b0;
    logic       reset, enable, moisture_valid, manual_req, sensor_enable;
    logic       watering_in_progress, clear_fault;
    logic [7:0] moisture, manual_dur;
    logic [7:0] irrigation_time, water_count, last_duration;
    logic       busy, fault;

    int n_checks = 0;
    int n_errors = 0;

    // pump controller responder
    bit   ctrl_on;
    int   ack_delay, water_len, c_left, c_cnt;
    logic wip_n;

    // reference model: pending request, watering flag, cooldown left, fault flag
    int m_irr, m_dur, m_age, m_cool, m_wc, m_ld;
    bit m_wat, m_fault;

    always #5 clk = ~clk;

    irrigation_scheduler dut (
        .clk                 (clk),
        .reset               (reset),
        .enable              (enable),
        .moisture            (moisture),
        .moisture_valid      (moisture_valid),
        .manual_req          (manual_req),
        .manual_dur          (manual_dur),
        .sensor_enable       (sensor_enable),
        .watering_in_progress(watering_in_progress),
        .clear_fault         (clear_fault),
        .irrigation_time     (irrigation_time),
        .busy                (busy),
        .fault               (fault),
        .water_count         (water_count),
        .last_duration       (last_duration)
    );

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== 32'(exp)) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int auto_dur(input int m);
        int d;
        d = DUR_BASE + (DRY_THRESH - m) / (1 << DUR_SHIFT);
        if (d > DUR_MAX) d = DUR_MAX;
        if (d < 1) d = 1;
        return d;
    endfunction

    task automatic model_edge();
        int d;
        if (reset) begin
            m_irr = 0; m_dur = 0; m_age = 0; m_cool = 0;
            m_wc = 0; m_ld = 0; m_wat = 0; m_fault = 0;
        end else if (m_fault) begin
            if (clear_fault) m_fault = 0;
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (m_wat) begin
            if (!watering_in_progress) begin
                m_wat  = 0;
                m_wc   = (m_wc < 255) ? m_wc + 1 : 255;
                m_ld   = m_dur;
                m_cool = COOLDOWN;
            end
        end else if (m_irr != 0) begin
            m_age++;
            if (watering_in_progress) begin
                m_wat = 1; m_irr = 0;
            end else if (m_age >= ACK_TIMEOUT) begin
                m_fault = 1; m_irr = 0;
            end
        end else if (enable && sensor_enable) begin
            d = 0;
            if (manual_req && manual_dur != 0) d = int'(manual_dur);
            else if (moisture_valid && int'(moisture) < DRY_THRESH) d = auto_dur(int'(moisture));
            if (d != 0) begin
                m_dur = d; m_irr = d; m_age = 0;
            end
        end
    endtask

    task automatic ctrl_edge();
        wip_n = watering_in_progress;
        if (!ctrl_on) begin
            wip_n = 1'b0; c_left = 0; c_cnt = 0;
        end else if (watering_in_progress) begin
            if (c_left <= 1) wip_n = 1'b0;
            c_left--;
        end else if (irrigation_time != 8'd0) begin
            c_cnt++;
            if (c_cnt >= ack_delay) begin
                wip_n = 1'b1; c_left = water_len; c_cnt = 0;
            end
        end else begin
            c_cnt = 0;
        end
    endtask

    // One clock: predict the edge, clock it, then compare every output against the model.
    task automatic step();
        model_edge();
        ctrl_edge();
        @(posedge clk);
        #1;
        watering_in_progress = wip_n;
        chk("irrigation_time", irrigation_time, m_irr);
        chk("busy", busy, int'((m_irr != 0) || m_wat || (m_cool > 0) || m_fault));
        chk("fault", fault, int'(m_fault));
        chk("water_count", water_count, m_wc);
        chk("last_duration", last_duration, m_ld);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; moisture = 8'd200; moisture_valid = 1'b0;
        manual_req = 1'b0; manual_dur = 8'd0; sensor_enable = 1'b1;
        watering_in_progress = 1'b0; clear_fault = 1'b0;
        ctrl_on = 1'b1; ack_delay = 1; water_len = 20; c_left = 0; c_cnt = 0;
        m_irr = 0; m_dur = 0; m_age = 0; m_cool = 0; m_wc = 0; m_ld = 0; m_wat = 0; m_fault = 0;
        @(negedge clk);
        steps(2);
        chk("reset_irr", irrigation_time, 0);
        chk("reset_busy", busy, 0);
        chk("reset_fault", fault, 0);
        chk("reset_wc", water_count, 0);
        chk("reset_ld", last_duration, 0);
        reset = 1'b0;
        steps(2);

        // auto request, moisture 60 -> 10 + 40/4 = 20
        enable = 1'b1; moisture = 8'd60; moisture_valid = 1'b1;
        step();
        chk("auto_irr", irrigation_time, 20);
        chk("auto_busy", busy, 1);
        moisture_valid = 1'b0;
        step();
        chk("auto_irr_2nd_cycle", irrigation_time, 20);
        step();
        chk("auto_irr_cleared", irrigation_time, 0);
        steps(20);
        chk("auto_wc", water_count, 1);
        chk("auto_ld", last_duration, 20);
        moisture_valid = 1'b1;
        steps(15);
        chk("cooldown_busy", busy, 1);
        chk("cooldown_irr", irrigation_time, 0);
        step();
        chk("cooldown_end_busy", busy, 0);
        step();
        chk("after_cooldown_irr", irrigation_time, 20);
        moisture_valid = 1'b0;
        steps(60);

        // saturation and threshold
        moisture = 8'd0; moisture_valid = 1'b1;
        step();
        chk("sat_irr", irrigation_time, 32);
        moisture_valid = 1'b0;
        steps(60);
        chk("sat_wc", water_count, 3);
        moisture = 8'd100; moisture_valid = 1'b1;
        steps(3);
        chk("thresh_busy", busy, 0);
        moisture = 8'd10; moisture_valid = 1'b0;
        steps(3);
        chk("invalid_busy", busy, 0);

        // manual priority
        manual_req = 1'b1; manual_dur = 8'd7; moisture = 8'd50; moisture_valid = 1'b1;
        step();
        chk("manual_irr", irrigation_time, 7);
        manual_req = 1'b0; moisture_valid = 1'b0;
        steps(60);
        chk("manual_ld", last_duration, 7);
        manual_req = 1'b1; manual_dur = 8'd0; moisture = 8'd150; moisture_valid = 1'b1;
        steps(3);
        chk("manual_zero_busy", busy, 0);
        manual_req = 1'b0; moisture_valid = 1'b0;
        clear_fault = 1'b1;
        step();
        clear_fault = 1'b0;
        chk("stray_clear_busy", busy, 0);

        // acknowledge timeout and fault clear
        ctrl_on = 1'b0;
        moisture = 8'd60; moisture_valid = 1'b1;
        step();
        moisture_valid = 1'b0;
        steps(7);
        chk("pre_timeout_fault", fault, 0);
        chk("pre_timeout_irr", irrigation_time, 20);
        step();
        chk("timeout_fault", fault, 1);
        chk("timeout_irr", irrigation_time, 0);
        enable = 1'b0;
        steps(3);
        chk("fault_sticky", fault, 1);
        clear_fault = 1'b1;
        step();
        clear_fault = 1'b0;
        chk("fault_cleared", fault, 0);
        chk("fault_cleared_busy", busy, 0);
        ctrl_on = 1'b1; enable = 1'b1; moisture_valid = 1'b1;
        step();
        chk("post_fault_irr", irrigation_time, 20);
        moisture_valid = 1'b0;
        steps(60);

        // ack on the timeout cycle wins
        ack_delay = ACK_TIMEOUT - 1;
        moisture = 8'd80; moisture_valid = 1'b1;
        step();
        chk("late_ack_irr", irrigation_time, 15);
        moisture_valid = 1'b0;
        steps(8);
        chk("late_ack_fault", fault, 0);
        chk("late_ack_irr_cleared", irrigation_time, 0);
        steps(60);
        chk("late_ack_wc", water_count, 6);
        ack_delay = 1;

        // gating
        enable = 1'b0; moisture = 8'd10; moisture_valid = 1'b1;
        steps(3);
        chk("gate_enable_busy", busy, 0);
        enable = 1'b1; sensor_enable = 1'b0;
        steps(3);
        chk("gate_sensor_busy", busy, 0);
        sensor_enable = 1'b1;
        step();
        chk("gate_release_irr", irrigation_time, 32);
        moisture_valid = 1'b0;
        steps(3);
        enable = 1'b0;
        steps(60);
        chk("enable_drop_wc", water_count, 7);

        // reset mid-WAIT_DONE and mid-REQ
        enable = 1'b1; moisture = 8'd60; moisture_valid = 1'b1;
        step();
        moisture_valid = 1'b0;
        steps(4);
        reset = 1'b1; enable = 1'b0;
        step();
        chk("rst_wait_wc", water_count, 0);
        chk("rst_wait_ld", last_duration, 0);
        chk("rst_wait_busy", busy, 0);
        reset = 1'b0;
        steps(30);
        ctrl_on = 1'b0; enable = 1'b1; moisture_valid = 1'b1;
        step();
        chk("rst_req_irr_before", irrigation_time, 20);
        moisture_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("rst_req_irr", irrigation_time, 0);
        chk("rst_req_busy", busy, 0);
        moisture_valid = 1'b1;
        steps(300);
        chk("rst_held_wc", water_count, 0);
        reset = 1'b0;

        // count saturation with short waterings, 20 cycles each
        ctrl_on = 1'b1; water_len = 1; moisture = 8'd60; moisture_valid = 1'b1; enable = 1'b1;
        steps(20 * 260);
        chk("wc_saturated", water_count, 255);
        moisture_valid = 1'b0;
        steps(40);
        chk("wc_saturated_hold", water_count, 255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/irrigation_scheduler.md
# irrigation_scheduler

Request-side counterpart of the pump controller. It samples the soil-moisture reading, decides whether watering is needed, and computes a watering duration. It then issues that duration on `irrigation_time` and tracks the controller's `watering_in_progress` handshake through completion and a cooldown. A manual override, an acknowledge timeout with sticky fault, and completion statistics are included.

## Interface
Parameters:
- `DRY_THRESH`, default 100: moisture strictly below this triggers automatic watering.
- `DUR_BASE`, default 10: base duration in cycles.
- `DUR_SHIFT`, default 2: the moisture deficit is right-shifted by this amount and added to `DUR_BASE`.
- `DUR_MAX`, default 32: saturation ceiling for the computed duration (1..255).
- `ACK_TIMEOUT`, default 8: cycles allowed in REQ for `watering_in_progress` to rise.
- `COOLDOWN`, default 16: idle cycles after a completed watering before the next decision.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  permits new requests; sampled only in IDLE.
- `moisture`  in  8  soil-moisture reading; 0 = dry.
- `moisture_valid`  in  1  `moisture` is valid this cycle.
- `manual_req`  in  1  level manual-watering request.
- `manual_dur`  in  8  manual duration; 0 = ignore the manual request.
- `sensor_enable`  in  1  from the pump controller; 1 = controller idle and ready.
- `watering_in_progress`  in  1  from the pump controller.
- `clear_fault`  in  1  single-cycle fault acknowledge.
- `irrigation_time`  out  8  requested duration to the controller; 0 = no request.
- `busy`  out  1  high in every state except IDLE.
- `fault`  out  1  high in FAULT.
- `water_count`  out  8  completed waterings; saturates at 255.
- `last_duration`  out  8  duration of the most recent completed watering.

## Operation
States: IDLE, REQ, WAIT_DONE, COOLDOWN, FAULT.

Reset values: state IDLE; `irrigation_time`=0, `busy`=0, `fault`=0, `water_count`=0, `last_duration`=0. All internal counters are 0.

IDLE:
- A decision is taken only when `enable`=1 and `sensor_enable`=1.
- Priority 1: `manual_req`=1 and `manual_dur`≠0 → duration = `manual_dur`, go to REQ.
- Priority 2: `moisture_valid`=1 and `moisture` < `DRY_THRESH` → duration = auto value (below), go to REQ.
- Otherwise remain in IDLE.

Auto duration:
- deficit = `DRY_THRESH` − `moisture` (8-bit, always ≥1).
- sum = `DUR_BASE` + (deficit >> `DUR_SHIFT`), computed at 9 bits.
- duration = min(sum, `DUR_MAX`), then raised to 1 if it is 0.

REQ:
- `irrigation_time` holds the latched duration; later input changes do not alter it.
- The timeout counter increments each cycle in REQ.
- `watering_in_progress`=1 → go to WAIT_DONE and clear `irrigation_time` to 0 at the same edge.
- Otherwise, counter reaches `ACK_TIMEOUT` → go to FAULT and clear `irrigation_time` to 0.

WAIT_DONE:
- `irrigation_time`=0.
- Stay while `watering_in_progress`=1.
- On 0: `water_count`+1 (saturating), `last_duration` ← latched duration, go to COOLDOWN.

COOLDOWN:
- Count `COOLDOWN` cycles, then go to IDLE.
- Inputs are ignored, including `manual_req`.

FAULT:
- `fault`=1, `irrigation_time`=0.
- `clear_fault`=1 → IDLE at the next edge.
- `enable` has no effect.

Other rules:
- `enable` dropping outside IDLE does not abort the current sequence.
- `reset` in any state returns the block to its reset values at the next edge. A request in flight is abandoned, and `irrigation_time` reads 0 on the following cycle.

## Timing
- Decision taken at edge k → `irrigation_time`≠0 and `busy`=1 from cycle k+1.
- The controller latches the request at edge k+1 and raises `watering_in_progress` in cycle k+2. The scheduler sees it at edge k+2, so `irrigation_time` is nonzero for exactly 2 cycles on a prompt ack.
- The nonzero window is therefore always ≥1 cycle and ≤ `ACK_TIMEOUT` cycles.
- Fault timing: with no ack, `fault` rises at cycle k+1+`ACK_TIMEOUT`.
- `watering_in_progress` falls at edge d → `water_count` and `last_duration` update visible from d+1.
- Cooldown: COOLDOWN is occupied for exactly `COOLDOWN` cycles; the earliest next decision is at edge d+1+`COOLDOWN`.
- Simultaneous ack and timeout in the same cycle: the ack wins.
- Simultaneous `manual_req` and a dry reading: the manual request wins.
- A `clear_fault` pulse outside FAULT is ignored.

## Test plan
- Auto request, default parameters, moisture=60 valid, controller model acks in 1 cycle and waters for 20 cycles → `irrigation_time`=20 for 2 cycles; after completion `water_count`=1 and `last_duration`=20; no new request for 16 cycles.
- Saturation and threshold: moisture=0 → `irrigation_time`=32 (sum 35 clamped to 32); moisture=100 or moisture_valid=0 → stays IDLE, `irrigation_time`=0.
- Manual priority: `manual_req`=1 with `manual_dur`=7 while moisture=50 → request 7. Then `manual_dur`=0 with moisture=150 → no request.
- Timeout: no controller response → `fault`=1 exactly `ACK_TIMEOUT`+1 cycles after the decision edge, `irrigation_time`=0; `clear_fault` pulse → IDLE, new request possible.
- Gating: `enable`=0 or `sensor_enable`=0 with moisture=10 → no request. `enable` dropped during WAIT_DONE → sequence completes and `water_count` increments.
- Reset mid-WAIT_DONE and mid-REQ → next cycle all outputs at reset values; `water_count` stays 0 after 300 completed cycles with a saturation check done separately (255 held).
